// File: rtl/lcd1602_responder.sv
// HD44780-compatible LCD-side bus responder with a 2x16 character mirror.
// Bus pins are synchronised, transfers are taken on the falling edge of en,
// and executed one cycle after detection.
module lcd1602_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       dat_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       overrun
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    // HD44780 address counter wrap: 0x27 -> 0x40, 0x67 -> 0x00; gap values normalise.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a >= 7'h27 && a <= 7'h3F) r = 7'h40;
            else if (a >= 7'h67)          r = 7'h00;
            else                          r = a + 7'd1;
        end else begin
            if (a == 7'h00)                    r = 7'h67;
            else if (a >= 7'h28 && a <= 7'h40) r = 7'h27;
            else if (a >= 7'h68)               r = 7'h67;
            else                               r = a - 7'd1;
        end
        return r;
    endfunction

    // Only 0x00-0x0F and 0x40-0x4F are visible on a 16-column display.
    function automatic logic on_screen(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

    function automatic logic [4:0] mem_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    logic             en_s1_q, en_s2_q, en_s3_q;
    logic             rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0]       dat_s1_q, dat_s2_q;
    logic             exec_q, exec_d;
    logic             cap_rs_q, cap_rs_d, cap_rw_q, cap_rw_d;
    logic [7:0]       cap_dat_q, cap_dat_d;
    logic [6:0]       ac_q, ac_d;
    logic             id_q, id_d, sh_q, sh_d;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [4:0]       clr_idx_q, clr_idx_d;
    logic [7:0]       mem_q [32];
    logic [7:0]       rd_data_q;
    logic             we;
    logic [4:0]       widx;
    logic [7:0]       wdata;
    logic             fall, busy_w;

    assign fall   = !en_s2_q && en_s3_q;
    assign busy_w = (cnt_q != '0);

    // Two-flop synchronisers for the asynchronous bus, plus a third en stage for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1_q  <= 1'b0; en_s2_q <= 1'b0; en_s3_q <= 1'b0;
            rs_s1_q  <= 1'b0; rs_s2_q <= 1'b0;
            rw_s1_q  <= 1'b0; rw_s2_q <= 1'b0;
            dat_s1_q <= 8'h00; dat_s2_q <= 8'h00;
        end else begin
            en_s1_q  <= en;    en_s2_q  <= en_s1_q; en_s3_q <= en_s2_q;
            rs_s1_q  <= rs;    rs_s2_q  <= rs_s1_q;
            rw_s1_q  <= rw;    rw_s2_q  <= rw_s1_q;
            dat_s1_q <= dat_i; dat_s2_q <= dat_s1_q;
        end
    end

    // Clear sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_idx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Transfer capture, instruction/data execution, busy counter and clear sequencing.
    always_comb begin
        exec_d    = 1'b0;
        cap_rs_d  = cap_rs_q;
        cap_rw_d  = cap_rw_q;
        cap_dat_d = cap_dat_q;
        ac_d      = ac_q;
        id_d      = id_q;
        sh_d      = sh_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        ovr_d     = ovr_q;
        cnt_d     = busy_w ? (cnt_q - CNT_W'(1)) : cnt_q;
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        we        = 1'b0;
        widx      = 5'd0;
        wdata     = 8'h00;

        if (fall) begin
            if (!rw_s2_q && busy_w) begin
                ovr_d = 1'b1;
            end else begin
                exec_d    = 1'b1;
                cap_rs_d  = rs_s2_q;
                cap_rw_d  = rw_s2_q;
                cap_dat_d = dat_s2_q;
                if (!rw_s2_q)
                    cnt_d = (!rs_s2_q && dat_s2_q == 8'h01) ? CNT_W'(CLEAR_CYCLES)
                                                            : CNT_W'(BUSY_CYCLES);
            end
        end

        if (exec_q) begin
            if (!cap_rw_q && cap_rs_q) begin
                if (on_screen(ac_q)) begin
                    we    = 1'b1;
                    widx  = mem_index(ac_q);
                    wdata = cap_dat_q;
                end
                ac_d = ac_step(ac_q, id_q);
            end else if (!cap_rw_q) begin
                casez (cap_dat_q)
                    8'b1???????: ac_d = cap_dat_q[6:0];
                    8'b0001????: if (!cap_dat_q[3]) ac_d = ac_step(ac_q, cap_dat_q[2]);
                    8'b00001???: begin
                        disp_d  = cap_dat_q[2];
                        cur_d   = cap_dat_q[1];
                        blink_d = cap_dat_q[0];
                    end
                    8'b000001??: begin
                        id_d = cap_dat_q[1];
                        sh_d = cap_dat_q[0];
                    end
                    8'b0000001?: ac_d = 7'h00;
                    8'b00000001: begin
                        ac_d      = 7'h00;
                        id_d      = 1'b1;
                        state_d   = ST_CLEAR;
                        clr_idx_d = 5'd0;
                    end
                    default: ;
                endcase
            end else if (cap_rs_q) begin
                ac_d = ac_step(ac_q, id_q);
            end
        end

        if (state_q == ST_CLEAR) begin
            we        = 1'b1;
            widx      = clr_idx_q;
            wdata     = 8'h20;
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) state_d = ST_IDLE;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q    <= 1'b0;
            cap_rs_q  <= 1'b0;
            cap_rw_q  <= 1'b0;
            cap_dat_q <= 8'h00;
            ac_q      <= 7'h00;
            id_q      <= 1'b1;
            sh_q      <= 1'b0;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            exec_q    <= exec_d;
            cap_rs_q  <= cap_rs_d;
            cap_rw_q  <= cap_rw_d;
            cap_dat_q <= cap_dat_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            sh_q      <= sh_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Display mirror; reset restores all blanks regardless of any clear in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    // Registered mirror read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= 8'h20;
        else        rd_data_q <= mem_q[rd_addr];
    end

    // Bus read data: busy flag/address or character under the address counter.
    always_comb begin
        dat_o = 8'h00;
        if (dat_oe) begin
            if (!rs_s2_q)             dat_o = {busy_w, ac_q};
            else if (on_screen(ac_q)) dat_o = mem_q[mem_index(ac_q)];
            else                      dat_o = 8'h20;
        end
    end

    assign dat_oe    = rw_s2_q && en_s2_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_w;
    assign disp_on   = disp_q;
    assign cursor_on = cur_q;
    assign blink_on  = blink_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Bench for lcd1602_responder: directed bus traffic with a scoreboard queue
// drained by an independent monitor.
module tb_lcd1602_responder;

    localparam int BUSY = 40;
    localparam int CLR  = 1600;
    localparam int K_BUS  = 0;
    localparam int K_MEM  = 1;
    localparam int K_STAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rs = 1'b0, rw = 1'b0, en = 1'b0;
    logic [7:0] dat_i = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] dat_o, rd_data;
    logic       dat_oe, busy, disp_on, cursor_on, blink_on, overrun;

    lcd1602_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR)) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rw(rw), .en(en), .dat_i(dat_i),
        .dat_o(dat_o), .dat_oe(dat_oe), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [7:0]  exp;
        logic [95:0] nm;
    } exp_t;

    exp_t sb_q[$];
    logic mem_req = 1'b0, stat_req = 1'b0, done = 1'b0;
    int   n_chk = 0, n_err = 0;

    task automatic push(input int k, input logic [7:0] e, input logic [95:0] nm);
        exp_t t;
        t.kind = k; t.exp = e; t.nm = nm;
        sb_q.push_back(t);
    endtask

    task automatic xfer(input logic r_s, input logic r_w, input logic [7:0] d);
        @(posedge clk); #1; rs = r_s; rw = r_w; dat_i = d;
        repeat (2) @(posedge clk); #1 en = 1'b1;
        repeat (4) @(posedge clk); #1 en = 1'b0;
        repeat (4) @(posedge clk); #1 rw = 1'b0;
    endtask

    task automatic wr(input logic r_s, input logic [7:0] d);
        xfer(r_s, 1'b0, d);
        repeat (BUSY + 5) @(posedge clk);
    endtask

    task automatic rd(input logic r_s, input logic [7:0] e, input logic [95:0] nm);
        push(K_BUS, e, nm);
        xfer(r_s, 1'b1, 8'h00);
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_mem(input logic [4:0] idx, input logic [7:0] e, input logic [95:0] nm);
        push(K_MEM, e, nm);
        @(posedge clk); #1 rd_addr = idx; mem_req = 1'b1;
        @(posedge clk); #1 mem_req = 1'b0;
    endtask

    // Status byte: {3'b0, busy, overrun, disp_on, cursor_on, blink_on}
    task automatic chk_stat(input logic [7:0] e, input logic [95:0] nm);
        push(K_STAT, e, nm);
        @(posedge clk); #1 stat_req = 1'b1;
        @(posedge clk); #1 stat_req = 1'b0;
    endtask

    task automatic chk_blank(input logic [95:0] nm);
        for (int i = 0; i < 32; i++) chk_mem(i[4:0], 8'h20, nm);
    endtask

    // Stimulus
    initial begin
        logic [79:0] msg;
        msg = "Wavesharer";
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk_stat(8'h00, "rst_stat");
        chk_mem(5'd0, 8'h20, "rst_mem0");
        chk_mem(5'd31, 8'h20, "rst_mem31");
        rd(1'b0, 8'h00, "rst_bf");

        wr(1'b0, 8'h38);
        wr(1'b0, 8'h0C);
        wr(1'b0, 8'h06);
        xfer(1'b0, 1'b0, 8'h01);
        repeat (CLR + 5) @(posedge clk);
        chk_stat(8'h04, "init_stat");
        chk_blank("init_blank");

        for (int i = 0; i < 10; i++) wr(1'b1, msg[8*(9-i) +: 8]);
        for (int i = 0; i < 10; i++) chk_mem(i[4:0], msg[8*(9-i) +: 8], "msg_mem");
        rd(1'b0, 8'h0A, "msg_ac");

        wr(1'b0, 8'hC0);
        wr(1'b1, 8'h41);
        wr(1'b1, 8'h42);
        chk_mem(5'd16, 8'h41, "l2_A");
        chk_mem(5'd17, 8'h42, "l2_B");
        rd(1'b0, 8'h42, "l2_ac");
        wr(1'b0, 8'hA7);
        rd(1'b0, 8'h27, "set27_ac");
        wr(1'b1, 8'h41);
        rd(1'b0, 8'h40, "wrap27_ac");
        chk_mem(5'd16, 8'h41, "offscr16");
        chk_mem(5'd9, 8'h72, "offscr9");

        wr(1'b0, 8'h04);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h58);
        chk_mem(5'd0, 8'h58, "dec_mem0");
        rd(1'b0, 8'h67, "dec_wrap0");
        wr(1'b0, 8'hC0);
        wr(1'b0, 8'h10);
        rd(1'b0, 8'h27, "dec_wrap40");
        wr(1'b0, 8'hB0);
        wr(1'b0, 8'h10);
        rd(1'b0, 8'h27, "dec_norm30");
        wr(1'b0, 8'h80);
        rd(1'b1, 8'h58, "dread0");
        rd(1'b0, 8'h67, "dread_ac");
        wr(1'b0, 8'h06);
        wr(1'b0, 8'hE7);
        wr(1'b0, 8'h14);
        rd(1'b0, 8'h00, "inc_wrap67");
        wr(1'b0, 8'h90);
        rd(1'b1, 8'h20, "dread_off");
        rd(1'b0, 8'h11, "dread_offac");
        wr(1'b0, 8'h0B);
        chk_stat(8'h03, "ctl_0B");
        wr(1'b0, 8'h0C);
        chk_stat(8'h04, "ctl_0C");

        xfer(1'b0, 1'b0, 8'h01);
        repeat (5) @(posedge clk);
        xfer(1'b1, 1'b0, 8'h55);
        chk_stat(8'h1C, "ovr_stat");
        rd(1'b0, 8'h80, "clr_bf");
        repeat (1450) @(posedge clk);
        chk_stat(8'h1C, "clr_busy");
        repeat (150) @(posedge clk);
        chk_stat(8'h0C, "clr_done");
        chk_blank("clr_blank");
        rd(1'b0, 8'h00, "clr_ac");

        wr(1'b0, 8'hC0);
        wr(1'b1, 8'h51);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h5A);
        chk_mem(5'd16, 8'h51, "pre_Q");
        chk_mem(5'd0, 8'h5A, "pre_Z");
        xfer(1'b0, 1'b0, 8'h01);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        chk_stat(8'h00, "mid_rst_st");
        chk_mem(5'd16, 8'h20, "mid_rst_rd");
        @(posedge clk); #1 rst_n = 1'b1;
        chk_blank("post_rst");
        wr(1'b1, 8'h4B);
        chk_mem(5'd0, 8'h4B, "post_wr0");
        chk_mem(5'd1, 8'h20, "post_wr1");
        rd(1'b0, 8'h01, "post_ac");
        chk_stat(8'h00, "post_stat");

        repeat (4) @(posedge clk);
        done = 1'b1;
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result
    initial begin
        logic oe_prev, mem_pend;
        int   cyc;
        oe_prev = 1'b0; mem_pend = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 60000) begin
                $display("FAIL watchdog: cycles=%0d limit=60000", cyc);
                $fatal(1, "watchdog");
            end
            if (dat_oe && !oe_prev) take(K_BUS, dat_o);
            if (mem_pend)           take(K_MEM, rd_data);
            if (stat_req)           take(K_STAT, {3'b000, busy, overrun, disp_on, cursor_on, blink_on});
            oe_prev  = dat_oe;
            mem_pend = mem_req;
            if (done) begin
                while (sb_q.size() != 0) begin
                    n_chk++; n_err++;
                    $display("FAIL %0s: never observed, expected %02h", sb_q[0].nm, sb_q[0].exp);
                    void'(sb_q.pop_front());
                end
                $display("Result: errors=%0d of %0d checks", n_err, n_chk);
                $finish;
            end
        end
    end

    task automatic take(input int k, input logic [7:0] act);
        exp_t t;
        n_chk++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected: kind=%0d got %02h with nothing pending", k, act);
        end else begin
            t = sb_q.pop_front();
            if (t.kind != k) begin
                n_err++;
                $display("FAIL %0s: output kind %0d got %02h, expected kind %0d value %02h",
                         t.nm, k, act, t.kind, t.exp);
            end else if (act !== t.exp) begin
                n_err++;
                $display("FAIL %0s: got %02h expected %02h", t.nm, act, t.exp);
            end
        end
    endtask

endmodule
